day_2_range_parser: RTL and testbench

- Streaming ASCII front end for the day 2 ID-range solver.
- Consumes puzzle text of the form "lo-hi,lo-hi,...\n" one byte per handshake and converts decimal text to binary.
- Writes each (lo, hi) pair into the solver's two range tables (low-bound table and high-bound table) through a single write port, replacing file preloading.
- Reports the range count, completion and error status.

---
 rtl/day_2_range_parser_if.sv | 32 +++
 rtl/day_2_range_parser.sv | 203 ++++++++++++++++++++
 tb/tb_day_2_range_parser.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/day_2_range_parser_if.sv
// Byte-stream input, table write port and status of the day 2 range parser.
// master: the side that feeds text and observes writes; slave: the parser itself.
interface day_2_range_parser_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_lo;
  logic [DATA_W-1:0] wr_hi;
  logic [ADDR_W:0]   range_count;
  logic              finished;
  logic              error;
  logic [2:0]        error_code;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_lo, wr_hi,
    input  range_count, finished, error, error_code
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_lo, wr_hi,
    output range_count, finished, error, error_code
  );
endinterface

// File: rtl/day_2_range_parser.sv
// Streams "lo-hi,lo-hi,...\n" ASCII text, converts decimal to binary and writes
// each (lo, hi) pair into the solver range tables, reporting count and error status.
module day_2_range_parser #(
  parameter int MAX_RANGES = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  day_2_range_parser_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_BAD   = 3'd1;
  localparam logic [2:0] E_OVF   = 3'd2;
  localparam logic [2:0] E_FULL  = 3'd3;
  localparam logic [2:0] E_ORDER = 3'd4;
  localparam logic [2:0] E_TRUNC = 3'd5;

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_lo;
  logic              r_seen;
  logic              r_to_done;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_lo;
  logic [DATA_W-1:0] r_wr_hi;
  logic [ADDR_W:0]   r_range_count;
  logic              r_finished;
  logic              r_error;
  logic [2:0]        r_error_code;

  logic              w_in_hi;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_digit;
  logic              w_is_nl;
  logic              w_is_sep;
  logic              w_is_blank;
  logic              w_is_dash;
  logic              w_term_done;
  logic [DATA_W+3:0] w_prod;
  logic [DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0] w_lo_next;
  logic              w_seen_next;
  logic              w_hi_next;
  logic              w_term;
  logic              w_done;
  logic [2:0]        w_err;

  assign w_in_hi     = (r_state == S_HI);
  assign bus.in_ready = (r_state == S_LO) || (r_state == S_HI) || (r_state == S_ERR);
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                     ((r_state == S_ERR) && r_finished));

  assign w_digit     = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign w_is_nl     = (bus.in_data == 8'h0A);
  assign w_is_sep    = (bus.in_data == 8'h2C) || w_is_nl;
  assign w_is_blank  = (bus.in_data == 8'h20) || (bus.in_data == 8'h0D);
  assign w_is_dash   = (bus.in_data == 8'h2D);
  assign w_term_done = w_is_nl || bus.in_last;

  // acc*10 + digit with 4 guard bits; any guard bit set means the value left DATA_W range
  assign w_prod = ({4'd0, r_acc} << 3) + ({4'd0, r_acc} << 1) +
                  {{DATA_W{1'b0}}, bus.in_data[3:0]};

  always_comb begin
    w_err       = E_NONE;
    w_term      = 1'b0;
    w_done      = 1'b0;
    w_acc_next  = r_acc;
    w_lo_next   = r_lo;
    w_seen_next = r_seen;
    w_hi_next   = w_in_hi;

    if (w_digit) begin
      if (|w_prod[DATA_W+3:DATA_W]) begin
        w_err = E_OVF;
      end else begin
        w_acc_next  = w_prod[DATA_W-1:0];
        w_seen_next = 1'b1;
      end
    end else if (w_is_blank) begin
      w_err = E_NONE;
    end else if (w_is_dash && !w_in_hi && r_seen) begin
      w_lo_next   = r_acc;
      w_acc_next  = '0;
      w_seen_next = 1'b0;
      w_hi_next   = 1'b1;
    end else if (w_is_sep && w_in_hi) begin
      if (r_seen) w_term = 1'b1;
      else        w_err  = E_TRUNC;
    end else if (w_is_nl && !w_in_hi && !r_seen) begin
      w_done = 1'b1;
    end else begin
      w_err = E_BAD;
    end

    // The last byte is processed first, then closes whatever range is open
    if (bus.in_last && (w_err == E_NONE) && !w_term && !w_done) begin
      if (w_hi_next && w_seen_next)        w_term = 1'b1;
      else if (!w_hi_next && !w_seen_next) w_done = 1'b1;
      else                                 w_err  = E_TRUNC;
    end

    if (w_term) begin
      if (w_acc_next < r_lo) begin
        w_err  = E_ORDER;
        w_term = 1'b0;
      end else if (r_range_count == (ADDR_W+1)'(MAX_RANGES)) begin
        w_err  = E_FULL;
        w_term = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_lo          <= '0;
      r_seen        <= 1'b0;
      r_to_done     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_lo       <= '0;
      r_wr_hi       <= '0;
      r_range_count <= '0;
      r_finished    <= 1'b0;
      r_error       <= 1'b0;
      r_error_code  <= E_NONE;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_state       <= S_LO;
        r_acc         <= '0;
        r_seen        <= 1'b0;
        r_range_count <= '0;
        r_finished    <= 1'b0;
        r_error       <= 1'b0;
        r_error_code  <= E_NONE;
      end else begin
        case (r_state)
          S_LO, S_HI: begin
            if (w_accept) begin
              r_acc  <= w_acc_next;
              r_lo   <= w_lo_next;
              r_seen <= w_seen_next;
              if (w_err != E_NONE) begin
                r_state      <= S_ERR;
                r_error      <= 1'b1;
                r_error_code <= w_err;
                r_finished   <= bus.in_last;
              end else if (w_term) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_range_count[ADDR_W-1:0];
                r_wr_lo   <= r_lo;
                r_wr_hi   <= w_acc_next;
                r_to_done <= w_term_done;
                r_state   <= S_WRITE;
              end else if (w_done) begin
                r_state    <= S_DONE;
                r_finished <= 1'b1;
              end else begin
                r_state <= w_hi_next ? S_HI : S_LO;
              end
            end
          end
          S_WRITE: begin
            r_range_count <= r_range_count + 1'b1;
            r_acc         <= '0;
            r_seen        <= 1'b0;
            if (r_to_done) begin
              r_state    <= S_DONE;
              r_finished <= 1'b1;
            end else begin
              r_state <= S_LO;
            end
          end
          S_ERR: begin
            if (!r_finished && w_accept && bus.in_last) r_finished <= 1'b1;
          end
          S_IDLE, S_DONE: r_state <= r_state;
          default:        r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_lo       = r_wr_lo;
  assign bus.wr_hi       = r_wr_hi;
  assign bus.range_count = r_range_count;
  assign bus.finished    = r_finished;
  assign bus.error       = r_error;
  assign bus.error_code  = r_error_code;

endmodule

// File: tb/tb_day_2_range_parser.sv
// Randomized and directed streams checked against a text-level model of the
// range grammar; one line is printed per stream.
module tb_day_2_range_parser;

  localparam int MAXR   = 2;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [63:0] lo;
    logic [63:0] hi;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_hs_cyc = -1;
  wr_t  got_q[$];

  day_2_range_parser_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  day_2_range_parser #(.MAX_RANGES(MAXR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Capture every table write; each strobe must sit in the cycle right after the terminator handshake
  always @(negedge clk) begin
    if (bus.wr_en) begin
      check_eq("wr_latency", cyc, last_hs_cyc);
      got_q.push_back('{addr: int'(bus.wr_addr), lo: bus.wr_lo, hi: bus.wr_hi});
    end
    if (bus.in_valid && bus.in_ready) last_hs_cyc = cyc + 1;
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: walk the text by the grammar rules with wide arithmetic
  function automatic void model(input bq_t s, output wr_t w[$], output int cnt, output int code);
    logic [127:0] acc, lo;
    bit hi_phase, seen, term, last;
    logic [7:0] c;
    acc = 0; lo = 0; hi_phase = 0; seen = 0; cnt = 0; code = 0;
    w.delete();
    for (int i = 0; i < s.size(); i++) begin
      c = s[i];
      last = (i == s.size() - 1);
      term = 0;
      if (c >= "0" && c <= "9") begin
        acc = acc * 10 + 128'(c - "0");
        if (acc > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin code = 2; return; end
        seen = 1;
      end else if (c == " " || c == 8'h0D) begin
      end else if (c == "-" && !hi_phase && seen) begin
        lo = acc; acc = 0; seen = 0; hi_phase = 1;
      end else if ((c == "," || c == 8'h0A) && hi_phase && seen) begin
        term = 1;
      end else if (c == 8'h0A && !hi_phase && !seen) begin
        return;
      end else begin
        code = (hi_phase && (c == "," || c == 8'h0A)) ? 5 : 1;
        return;
      end
      if (last && !term) begin
        if (hi_phase && seen) term = 1;
        else if (!hi_phase && !seen) return;
        else begin code = 5; return; end
      end
      if (term) begin
        if (acc < lo) begin code = 4; return; end
        if (cnt == MAXR) begin code = 3; return; end
        w.push_back('{addr: cnt, lo: lo[63:0], hi: acc[63:0]});
        cnt++;
        acc = 0; seen = 0; hi_phase = 0;
        if (c == 8'h0A || last) return;
      end
    end
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic send(input bq_t q, input bit mark_last, input bit stall);
    for (int i = 0; i < q.size(); i++) begin
      int  gap;
      int  t;
      bit  hs;
      gap = (stall && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      bus.in_last  = mark_last && (i == q.size() - 1);
      hs = 0; t = 0;
      while (!hs) begin
        @(negedge clk); hs = bus.in_ready;
        @(posedge clk); #1;
        t++;
        if (!hs && t > 50) begin
          check_eq("accept_timeout", 0, 1);
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
          return;
        end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic run_stream(input string name, input bq_t q, input bit stall);
    wr_t exp_q[$];
    int  exp_cnt, exp_code, t;
    model(q, exp_q, exp_cnt, exp_code);
    got_q.delete();
    pulse_start();
    send(q, 1'b1, stall);
    t = 0;
    @(negedge clk);
    while (!bus.finished && t < 40) begin @(negedge clk); t++; end
    check_eq({name, "/finished"}, bus.finished, 1);
    check_eq({name, "/count"}, bus.range_count, exp_cnt);
    check_eq({name, "/error"}, bus.error, exp_code != 0);
    check_eq({name, "/code"}, bus.error_code, exp_code);
    check_eq({name, "/n_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq({name, "/wr_addr"}, got_q[i].addr, exp_q[i].addr);
      check_eq({name, "/wr_lo"}, got_q[i].lo, exp_q[i].lo);
      check_eq({name, "/wr_hi"}, got_q[i].hi, exp_q[i].hi);
    end
    if (exp_code == 0) check_eq({name, "/done_not_ready"}, bus.in_ready, 0);
    $display("stream %s: bytes=%0d writes=%0d count=%0d code=%0d (expected writes=%0d code=%0d)",
             name, q.size(), got_q.size(), bus.range_count, bus.error_code, exp_q.size(), exp_code);
  endtask

  function automatic void append_num(inout bq_t q, input logic [127:0] v);
    logic [7:0] d[$];
    if ($urandom_range(0, 9) == 0) q.push_back(" ");
    if ($urandom_range(0, 9) == 0) q.push_back("0");
    if (v == 0) d.push_back("0");
    while (v != 0) begin
      d.push_front(8'h30 + 8'(v % 10));
      v = v / 10;
    end
    foreach (d[i]) q.push_back(d[i]);
  endfunction

  function automatic logic [127:0] pick_num();
    case ($urandom_range(0, 9))
      0, 1, 2: return 128'($urandom_range(0, 99));
      3, 4:    return 128'($urandom_range(0, 99999));
      5, 6:    return {64'd0, $urandom, $urandom};
      7:       return 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
      8:       return 128'h0000_0000_0000_0001_0000_0000_0000_0000;
      default: return 128'($urandom_range(1000, 5000));
    endcase
  endfunction

  function automatic bq_t gen_stream();
    bq_t q;
    int  n;
    logic [127:0] lo, hi;
    n = $urandom_range(1, 3);
    for (int r = 0; r < n; r++) begin
      lo = pick_num();
      hi = ($urandom_range(0, 5) == 0) ? pick_num() : lo + 128'($urandom_range(0, 1000));
      append_num(q, lo);
      if ($urandom_range(0, 14) == 0) q.push_back("x");
      q.push_back("-");
      if ($urandom_range(0, 11) != 0) append_num(q, hi);
      if ($urandom_range(0, 9) == 0) q.push_back(8'h0D);
      if (r < n - 1) q.push_back(",");
    end
    if ($urandom_range(0, 1) == 0) q.push_back(8'h0A);
    return q;
  endfunction

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    #23;
    check_eq("rst/in_ready", bus.in_ready, 0);
    check_eq("rst/wr_en", bus.wr_en, 0);
    check_eq("rst/count", bus.range_count, 0);
    check_eq("rst/status", {bus.finished, bus.error, bus.error_code}, 0);
    check_eq("rst/wr_bus", {bus.wr_addr, bus.wr_lo, bus.wr_hi}, 0);
    rst = 1'b0;

    run_stream("two_ranges", str2q("11-22,95-115\n"), 1'b0);
    run_stream("last_on_digit", str2q("998-1012"), 1'b1);
    run_stream("overflow", str2q("5-18446744073709551616\n"), 1'b0);
    run_stream("max_value", str2q("5-18446744073709551615\n"), 1'b1);
    run_stream("order", str2q("5-3\n"), 1'b0);
    run_stream("trunc", str2q("7-\n"), 1'b0);
    run_stream("full", str2q("1-1,2-2,3-3\n"), 1'b0);
    run_stream("bad_char", str2q("1a-2\n"), 1'b1);

    // Reset in the middle of a stream
    got_q.delete();
    pulse_start();
    send(str2q("1"), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst/in_ready", bus.in_ready, 0);
    check_eq("midrst/status", {bus.finished, bus.error, bus.error_code, bus.range_count}, 0);
    check_eq("midrst/wr_en", bus.wr_en, 0);
    #2 rst = 1'b0;
    check_eq("midrst/no_writes", got_q.size(), 0);
    $display("stream mid_reset: outputs cleared=%0d", !bus.finished && !bus.error);

    run_stream("after_reset", str2q("4-9\n"), 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_stream($sformatf("rand%0d", k), gen_stream(), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
